// File: rtl/alu_disp_pkg.sv
// Shared definitions for the calculator result display: symbol codes,
// active-high segment patterns and display state encodings.
package alu_disp_pkg;

  typedef enum logic [3:0] {
    DIG_0     = 4'd0,
    DIG_1     = 4'd1,
    DIG_2     = 4'd2,
    DIG_3     = 4'd3,
    DIG_4     = 4'd4,
    DIG_5     = 4'd5,
    DIG_6     = 4'd6,
    DIG_7     = 4'd7,
    DIG_8     = 4'd8,
    DIG_9     = 4'd9,
    SYM_MINUS = 4'd10,
    SYM_E     = 4'd11,
    SYM_R     = 4'd12,
    SYM_BLANK = 4'd13
  } sym_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DIG_0 = 7'h3F;
  localparam logic [6:0] SEG_DIG_1 = 7'h06;
  localparam logic [6:0] SEG_DIG_2 = 7'h5B;
  localparam logic [6:0] SEG_DIG_3 = 7'h4F;
  localparam logic [6:0] SEG_DIG_4 = 7'h66;
  localparam logic [6:0] SEG_DIG_5 = 7'h6D;
  localparam logic [6:0] SEG_DIG_6 = 7'h7D;
  localparam logic [6:0] SEG_DIG_7 = 7'h07;
  localparam logic [6:0] SEG_DIG_8 = 7'h7F;
  localparam logic [6:0] SEG_DIG_9 = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/result_display_seg7_encode.sv
// Symbol code to active-high 7-segment pattern; unused codes render blank.
module seg7_encode
  import alu_disp_pkg::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (sym)
      DIG_0:     seg = SEG_DIG_0;
      DIG_1:     seg = SEG_DIG_1;
      DIG_2:     seg = SEG_DIG_2;
      DIG_3:     seg = SEG_DIG_3;
      DIG_4:     seg = SEG_DIG_4;
      DIG_5:     seg = SEG_DIG_5;
      DIG_6:     seg = SEG_DIG_6;
      DIG_7:     seg = SEG_DIG_7;
      DIG_8:     seg = SEG_DIG_8;
      DIG_9:     seg = SEG_DIG_9;
      SYM_MINUS: seg = SEG_MINUS;
      SYM_E:     seg = SEG_E;
      SYM_R:     seg = SEG_R;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Captures the sign-magnitude ALU result and drives a scanned 4-digit
// common-anode 7-segment display showing the value or "Err".
module result_display
  import alu_disp_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [4:0] i_result,
  input  logic       i_DZF,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [3:0] o_an,
  output logic       o_ack,
  output logic       o_err
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [1:0]       idx_reg, idx_next;
  logic [4:0]       result_reg;
  logic             dzf_reg;
  logic             ack_reg;
  logic [6:0]       seg_reg;
  logic [3:0]       an_reg;
  logic             err_reg;

  logic [3:0] mag;
  logic       neg;
  logic       is_err;
  logic [3:0] digit_code [4];
  logic [3:0] an_onehot;
  logic [3:0] sym_sel;
  logic [6:0] seg_pat;

  assign mag    = result_reg[3:0];
  assign neg    = result_reg[4];
  assign is_err = dzf_reg | (mag > 4'd9);

  // Negative zero shows as plain "0": the minus needs a nonzero magnitude.
  always_comb begin
    digit_code[0] = SYM_BLANK;
    digit_code[1] = SYM_BLANK;
    digit_code[2] = SYM_BLANK;
    digit_code[3] = SYM_BLANK;
    if (is_err) begin
      digit_code[3] = SYM_E;
      digit_code[2] = SYM_R;
      digit_code[1] = SYM_R;
    end else begin
      digit_code[0] = mag;
      if (neg && (mag != 4'd0)) digit_code[1] = SYM_MINUS;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_onehot[gi] = (idx_reg == 2'(gi));
  end

  assign sym_sel = digit_code[idx_reg];

  seg7_encode u_seg7_encode (
    .sym (sym_sel),
    .seg (seg_pat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= BLANK;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    idx_next   = idx_reg;
    case (state_reg)
      BLANK: begin
        if (i_valid) state_next = SHOW;
      end
      SHOW: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          idx_next = idx_reg + 2'd1;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  // Anode and segments are registered from the same index, so they stay paired.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
      dzf_reg    <= 1'b0;
      ack_reg    <= 1'b0;
      seg_reg    <= '0;
      an_reg     <= '0;
      err_reg    <= 1'b0;
    end else begin
      div_reg <= div_next;
      idx_reg <= idx_next;
      ack_reg <= i_valid;
      if (i_valid) begin
        result_reg <= i_result;
        dzf_reg    <= i_DZF;
      end
      err_reg <= is_err;
      if (state_reg == SHOW) begin
        an_reg  <= an_onehot;
        seg_reg <= seg_pat;
      end else begin
        an_reg  <= '0;
        seg_reg <= '0;
      end
    end
  end

  assign o_an  = AN_ACTIVE_LOW ? ~an_reg : an_reg;
  assign o_seg = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;
  assign o_dp  = SEG_ACTIVE_LOW;
  assign o_ack = ack_reg;
  assign o_err = err_reg;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed scenarios followed by
// random captures, compared every cycle against a behavioural display model.
module tb_result_display;

  localparam int CLK_DIV = 4;

  logic       i_clk;
  logic       i_rst;
  logic       i_valid;
  logic [4:0] i_result;
  logic       i_DZF;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [3:0] o_an;
  logic       o_ack;
  logic       o_err;

  int checks   = 0;
  int failures = 0;

  // Model state: captured value, whether the display is running, and the
  // number of edges since the display started.
  logic       m_show;
  int         m_n;
  logic [4:0] m_res;
  logic       m_dzf;

  result_display #(
    .CLK_DIV        (CLK_DIV),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_result (i_result),
    .i_DZF    (i_DZF),
    .o_seg    (o_seg),
    .o_dp     (o_dp),
    .o_an     (o_an),
    .o_ack    (o_ack),
    .o_err    (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pin pattern (active-low) expected on digit d for a given captured value.
  function automatic logic [6:0] exp_pins(input logic [4:0] res, input logic dzf, input int d);
    logic [6:0] digits [10];
    logic [6:0] hi;
    int         mag;
    digits = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    hi  = 7'h00;
    mag = int'(res[3:0]);
    if (dzf || mag > 9) begin
      if (d == 3) hi = 7'h79;
      else if (d == 2 || d == 1) hi = 7'h50;
    end else if (d == 0) begin
      hi = digits[mag];
    end else if (d == 1 && res[4] && mag != 0) begin
      hi = 7'h40;
    end
    return ~hi;
  endfunction

  task automatic step(input logic rst, input logic valid, input logic [4:0] res, input logic dzf);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ack;
    logic       e_err;
    int         d;
    @(negedge i_clk);
    i_rst    = rst;
    i_valid  = valid;
    i_result = res;
    i_DZF    = dzf;
    @(posedge i_clk);
    if (rst) begin
      m_show = 1'b0;
      m_n    = 0;
      m_res  = '0;
      m_dzf  = 1'b0;
      e_an   = 4'b1111;
      e_seg  = 7'h7F;
      e_ack  = 1'b0;
      e_err  = 1'b0;
    end else begin
      e_an  = 4'b1111;
      e_seg = 7'h7F;
      if (m_show) begin
        m_n++;
        d     = ((m_n - 1) / CLK_DIV) % 4;
        e_an  = ~(4'b0001 << d);
        e_seg = exp_pins(m_res, m_dzf, d);
      end
      e_err = m_dzf || (m_res[3:0] > 4'd9);
      e_ack = valid;
      if (valid) begin
        m_res = res;
        m_dzf = dzf;
        if (!m_show) begin
          m_show = 1'b1;
          m_n    = 0;
        end
        $display("txn result=%b dzf=%b", res, dzf);
      end
    end
    #1;
    check("an",  32'(o_an),  32'(e_an));
    check("seg", 32'(o_seg), 32'(e_seg));
    check("ack", 32'(o_ack), 32'(e_ack));
    check("err", 32'(o_err), 32'(e_err));
    check("dp",  32'(o_dp),  32'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_result = '0;
    i_DZF    = 1'b0;
    m_show   = 1'b0;
    m_n      = 0;
    m_res    = '0;
    m_dzf    = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 1'b0);
    idle(40);

    step(1'b0, 1'b1, 5'b10110, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 5'b10000, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 5'b00000, 1'b1);
    idle(20);
    step(1'b0, 1'b1, 5'b00011, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 5'b01100, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 5'b10111, 1'b0);
    step(1'b0, 1'b1, 5'b00101, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 5'b11001, 1'b0);
    idle(12);

    for (int i = 0; i < 400; i++) begin
      logic r;
      logic v;
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 5) == 0);
      step(r, v, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
